// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 8 data bits LSB first, optional parity, 1 stop; rxdone ~2+9.5 bit times after the start edge.
// No backpressure: each byte is strobed once and held on rxout until the next frame.
`timescale 1ns/1ps
module uart_rx_os #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rxout,
  output logic       rxdone,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);
  localparam int   TICK_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int   TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int   TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int   PW       = $clog2(OVERSAMPLE);
  localparam logic PAR_EN   = (PARITY_EN != 0);
  localparam logic PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t          state, state_nx;
  logic            rx_m, rx_s;
  logic [TW-1:0]   tick_cnt;
  logic [PW-1:0]   phase;
  logic            tick, sample;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_q;
  logic            cnt_clr, shift_en, par_en, done_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Counters sit at zero in IDLE so the first tick is aligned to the start edge.
  assign tick   = (tick_cnt == TW'(TICK_DIV - 1));
  assign sample = tick && (phase == PW'(OVERSAMPLE / 2 - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      phase    <= '0;
    end else if (cnt_clr) begin
      tick_cnt <= '0;
      phase    <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      phase    <= (phase == PW'(OVERSAMPLE - 1)) ? '0 : phase + PW'(1);
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (!rx_s) state_nx = S_START;
      S_START:  if (sample) state_nx = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (sample && bit_cnt == 3'd7) state_nx = PAR_EN ? S_PARITY : S_STOP;
      S_PARITY: if (sample) state_nx = S_STOP;
      // Leave at mid-stop so a back-to-back start edge is caught.
      S_STOP:   if (sample) state_nx = rx_s ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx_s) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    cnt_clr  = (state == S_IDLE);
    shift_en = (state == S_DATA)   && sample;
    par_en   = (state == S_PARITY) && sample;
    done_en  = (state == S_STOP)   && sample;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= '0;
      bit_cnt    <= '0;
      par_q      <= 1'b0;
      rxout      <= '0;
      rxdone     <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rxdone <= done_en;
      if (cnt_clr) bit_cnt <= '0;
      if (shift_en) begin
        shift   <= {rx_s, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en) par_q <= ((^shift) ^ rx_s) != PAR_ODD;
      if (done_en) begin
        rxout      <= shift;
        frame_err  <= ~rx_s;
        parity_err <= PAR_EN & par_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 receiver and an 8E1 receiver share one serial line driven by bench tasks;
// a scoreboard derives byte, error flags and strobe latency from each frame as it is sent.
`timescale 1ns/1ps
module tb_uart_rx_os;
  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int BIT_CLK  = 16;
  localparam int LAT_NP   = 155;   // clk edges from start edge to rxdone, 8N1
  localparam int LAT_P    = 171;   // one extra bit time with parity

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] np_rxout, p_rxout;
  logic       np_rxdone, p_rxdone, np_fe, p_fe, np_pe, p_pe, np_busy, p_busy;

  int cyc  = 0;
  int nvec = 0;
  int nerr = 0;
  bit en_np = 1'b0;
  bit en_p  = 1'b0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         t0;
  } exp_t;
  exp_t q_np[$];
  exp_t q_p[$];

  typedef struct {
    logic [7:0] d;
    bit         pm;
    bit         pbit;
    bit         stop;
    int         gap;
    logic [7:0] xd;
    bit         xfe;
    bit         xpe;
  } vec_t;
  vec_t vt[8];

  uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rxout(np_rxout), .rxdone(np_rxdone),
    .frame_err(np_fe), .parity_err(np_pe), .busy(np_busy));

  uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rxout(p_rxout), .rxdone(p_rxdone),
    .frame_err(p_fe), .parity_err(p_pe), .busy(p_busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Even parity: a frame is bad when data plus parity bit hold an odd number of ones.
  function automatic bit model_perr(input logic [7:0] d, input bit pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    return (ones % 2) != 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic judge(input string nm, input exp_t e, input logic [7:0] d,
                       input logic fe, input logic pe, input int lat_nom);
    int lat;
    lat = cyc - e.t0;
    nvec++;
    if (d !== e.d || fe !== e.fe || pe !== e.pe || lat < lat_nom - 2 || lat > lat_nom) begin
      nerr++;
      $display("FAIL %s: got rxout=%h fe=%b pe=%b lat=%0d, expected rxout=%h fe=%b pe=%b lat=%0d..%0d",
               nm, d, fe, pe, lat, e.d, e.fe, e.pe, lat_nom - 2, lat_nom);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && en_np && np_rxdone) begin
        if (q_np.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL np_unexpected_rxdone: got strobe with rxout=%h, expected none", np_rxout);
        end else begin
          e = q_np.pop_front();
          judge("np_frame", e, np_rxout, np_fe, np_pe, LAT_NP);
        end
      end
      if (rst_n && en_p && p_rxdone) begin
        if (q_p.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL p_unexpected_rxdone: got strobe with rxout=%h, expected none", p_rxout);
        end else begin
          e = q_p.pop_front();
          judge("p_frame", e, p_rxout, p_fe, p_pe, LAT_P);
        end
      end
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLK) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pm, input bit pbit, input bit stop,
                            input logic [7:0] xd, input bit xfe, input bit xpe);
    exp_t e;
    e.d = xd; e.fe = xfe; e.pe = xpe; e.t0 = cyc;
    if (pm) q_p.push_back(e);
    else    q_np.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pm) drive_bit(pbit);
    drive_bit(stop);
  endtask

  task automatic apply_vec(input int i);
    send_frame(vt[i].d, vt[i].pm, vt[i].pbit, vt[i].stop, vt[i].xd, vt[i].xfe, vt[i].xpe);
    idle_bits(vt[i].gap);
    if (vt[i].gap > 0) chk("idle_after_frame", vt[i].pm ? p_busy : np_busy, 0);
  endtask

  initial begin
    int         bcnt;
    logic [7:0] d;
    bit         stop, pbit;

    vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 2, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0};
    vt[2] = '{8'hFF, 1'b0, 1'b0, 1'b1, 0, 8'hFF, 1'b0, 1'b0};
    vt[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 3, 8'h3C, 1'b0, 1'b0};
    vt[4] = '{8'h07, 1'b1, 1'b1, 1'b1, 2, 8'h07, 1'b0, 1'b0};
    vt[5] = '{8'h07, 1'b1, 1'b0, 1'b1, 2, 8'h07, 1'b0, 1'b1};
    vt[6] = '{8'h3C, 1'b1, 1'b0, 1'b1, 2, 8'h3C, 1'b0, 1'b0};
    vt[7] = '{8'h81, 1'b1, 1'b1, 1'b0, 2, 8'h81, 1'b1, 1'b1};

    fork monitor(); join_none

    rst_n = 1'b0;
    rx    = 1'b1;
    #12;
    chk("reset_rxout", np_rxout, 0);
    chk("reset_rxdone", np_rxdone, 0);
    chk("reset_frame_err", np_fe, 0);
    chk("reset_parity_err", np_pe, 0);
    chk("reset_busy", np_busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("idle_busy", np_busy, 0);
    en_np = 1'b1;

    // Single byte, then three back-to-back frames with no idle gap.
    for (int i = 0; i < 4; i++) apply_vec(i);
    repeat (20) @(posedge clk); #1;
    chk("b2b_all_strobes_seen", q_np.size(), 0);
    chk("rxout_held", np_rxout, 8'h3C);

    // Short low glitch on an idle line.
    bcnt = 0;
    rx = 1'b0;
    repeat (4) @(posedge clk); #1;
    rx = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (np_busy) bcnt++;
    end
    #1;
    chk("glitch_busy_cycles_ok", (bcnt >= 6 && bcnt <= 8), 1);
    chk("glitch_back_idle", np_busy, 0);

    // Stop bit low, line held low afterwards, then a clean frame.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0);
    repeat (40) @(posedge clk); #1;
    chk("break_busy_held", np_busy, 1);
    rx = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("break_released", np_busy, 0);
    idle_bits(2);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
    idle_bits(2);
    chk("break_all_strobes_seen", q_np.size(), 0);
    chk("after_break_rxout", np_rxout, 8'h12);

    // Reset in the middle of bit 3 of a 0xC3 frame (line low at that point).
    en_np = 1'b0;
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
    rx = 1'b0;
    repeat (8) @(posedge clk); #1;
    chk("midframe_busy", np_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_rxout", np_rxout, 0);
    chk("midreset_frame_err", np_fe, 0);
    chk("midreset_busy", np_busy, 0);
    chk("midreset_busy_p", p_busy, 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    idle_bits(15);
    en_np = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    idle_bits(2);
    chk("after_reset_rxout", np_rxout, 8'hC3);

    // Random 8N1 frames, occasional bad stop bit.
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, 1'b0, 1'b0, stop, d, !stop, 1'b0);
      idle_bits(stop ? $urandom_range(0, 2) : 1);
    end
    idle_bits(15);
    chk("np_all_strobes_seen", q_np.size(), 0);

    en_np = 1'b0;
    en_p  = 1'b1;
    for (int i = 4; i < 8; i++) apply_vec(i);

    // Random 8E1 frames with random parity bit and occasional bad stop bit.
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom_range(0, 255));
      pbit = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, 1'b1, pbit, stop, d, !stop, model_perr(d, pbit));
      idle_bits(stop ? $urandom_range(0, 2) : 1);
    end
    idle_bits(15);
    chk("p_all_strobes_seen", q_p.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
